// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit controller that owns the
// architectural HI/LO registers.
// A mult/multu/div/divu starts when the E-stage op is valid and the unit is
// idle. The unit stays busy for a fixed number of cycles and writes HI/LO on
// the final edge. mthi/mtlo write directly. mfhi/mflo are read through rdata.
// Define MDU_DIV_EN to build the divider path (div/divu and the DIV state).
// Without MDU_DIV_EN, ops 3/4 act as no-ops.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    s_idle = 2'd0,
    s_mul  = 2'd1
`ifdef MDU_DIV_EN
    , s_div = 2'd2
`endif
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;
  logic [31:0]   a_reg, a_next;
  logic [31:0]   b_reg, b_next;
  logic [3:0]    op_reg, op_next;

  logic          is_mul_op;
  logic          is_div_op;
  logic          start;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;

  // Classify the incoming E-stage opcode; divide ops only exist when built in
  always_comb begin
    is_mul_op = (op == 4'd1) || (op == 4'd2);
`ifdef MDU_DIV_EN
    is_div_op = (op == 4'd3) || (op == 4'd4);
`else
    is_div_op = 1'b0;
`endif
  end

  assign busy  = (state_reg != s_idle);
  assign start = en & (is_mul_op | is_div_op) & ~busy;
  assign stall = d_is_md & (busy | start);
  assign hi    = hi_reg;
  assign lo    = lo_reg;

  // Products are formed from the latched operands and consumed on the last busy edge
  assign prod_s = $signed(a_reg) * $signed(b_reg);
  assign prod_u = {32'd0, a_reg} * {32'd0, b_reg};

`ifdef MDU_DIV_EN
  logic [31:0] quo, rem;

  // Quotient/remainder of the latched operands; the most-negative / -1 case is pinned explicitly
  always_comb begin
    quo = '0;
    rem = '0;
    if (b_reg != 32'd0) begin
      if (op_reg == 4'd3) begin
        if (a_reg == 32'h8000_0000 && b_reg == 32'hFFFF_FFFF) begin
          quo = 32'h8000_0000;
          rem = 32'd0;
        end else begin
          quo = $signed(a_reg) / $signed(b_reg);
          rem = $signed(a_reg) % $signed(b_reg);
        end
      end else begin
        quo = a_reg / b_reg;
        rem = a_reg % b_reg;
      end
    end
  end
`endif

  // Next-state, counter, operand latch and HI/LO write logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    op_next    = op_reg;
    case (state_reg)
      s_idle: begin
        if (start) begin
          a_next  = rs_val;
          b_next  = rt_val;
          op_next = op;
          if (is_mul_op) begin
            state_next = s_mul;
            cnt_next   = CW'(MULT_CYCLES);
          end
`ifdef MDU_DIV_EN
          else begin
            state_next = s_div;
            cnt_next   = CW'(DIV_CYCLES);
          end
`endif
        end else if (en && op == 4'd5) begin
          hi_next = rs_val;
        end else if (en && op == 4'd6) begin
          lo_next = rs_val;
        end
      end
      s_mul: begin
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg <= CW'(1)) begin
          state_next = s_idle;
          if (op_reg == 4'd2) begin
            {hi_next, lo_next} = prod_u;
          end else begin
            {hi_next, lo_next} = prod_s;
          end
        end
      end
`ifdef MDU_DIV_EN
      s_div: begin
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg <= CW'(1)) begin
          state_next = s_idle;
          // A zero divisor still burns the full latency but leaves HI/LO alone
          if (b_reg != 32'd0) begin
            hi_next = rem;
            lo_next = quo;
          end
        end
      end
`endif
      default: begin
        state_next = s_idle;
        cnt_next   = '0;
      end
    endcase
  end

  // State and datapath registers; reset wins over any start or move-to
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= s_idle;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
    end
  end

  // mfhi/mflo read port, independent of en
  always_comb begin
    rdata = '0;
    if (op == 4'd7) begin
      rdata = hi_reg;
    end else if (op == 4'd8) begin
      rdata = lo_reg;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl.
// Expected HI/LO pairs are queued when an operation is issued and popped when
// busy falls. The divide tests run only when MDU_DIV_EN is defined. Otherwise
// the bench checks that ops 3/4 are ignored.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;

  logic [63:0] sb_q[$];
  logic [31:0] m_hi, m_lo;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .d_is_md(d_is_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one multi-cycle op, optionally hammer the unit while busy, then check result
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int n, input string tag,
                        input bit interfere);
    logic [63:0] got;
    int cycles;
    sb_q.push_back(exp);
    @(negedge clk);
    en = 1'b1; op = o; rs_val = a; rt_val = b; d_is_md = 1'b1;
    #1;
    check({tag, "_stall_start"}, 64'(stall), 64'd1);
    @(posedge clk); #1;
    en = 1'b0; op = 4'd0;
    cycles = 0;
    while (busy && cycles < 100) begin
      check({tag, "_stall_busy"}, 64'(stall), 64'd1);
      if (interfere) begin
        check({tag, "_lo_hold"}, 64'(lo), 64'(m_lo));
        en = 1'b1;
        op = (cycles % 2 == 0) ? 4'd6 : 4'd1;
        rs_val = 32'hDEAD_BEEF;
        rt_val = 32'h0000_0007;
      end
      @(posedge clk); #1;
      en = 1'b0; op = 4'd0;
      cycles++;
    end
    check({tag, "_busy_cycles"}, 64'(cycles), 64'(n));
    check({tag, "_stall_after"}, 64'(stall), 64'd0);
    got = sb_q.pop_front();
    check({tag, "_hilo"}, {hi, lo}, got);
    {m_hi, m_lo} = got;
    d_is_md = 1'b0;
    $display("[TB] %s op=%0d rs=%h rt=%h -> hi=%h lo=%h busy_cycles=%0d",
             tag, o, a, b, hi, lo, cycles);
  endtask

  // Single-cycle move-to-HI/LO
  task automatic mt(input logic [3:0] o, input logic [31:0] v);
    @(negedge clk);
    en = 1'b1; op = o; rs_val = v;
    @(posedge clk); #1;
    en = 1'b0; op = 4'd0;
    if (o == 4'd5) m_hi = v; else m_lo = v;
    $display("[TB] mt op=%0d val=%h -> hi=%h lo=%h", o, v, hi, lo);
  endtask

  initial begin
    logic [31:0] ra, rb;
    longint      sp;
    longint unsigned up;

    reset = 1'b1; en = 1'b0; op = 4'd0; rs_val = '0; rt_val = '0; d_is_md = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    reset = 1'b0; d_is_md = 1'b0;

    // Signed and unsigned multiply on the same operands
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5, "mult_neg2x3", 1'b0);
    run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 5, "multu_x3", 1'b0);

    // A few random operand pairs against a 64-bit integer model
    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      sp = longint'($signed(ra)) * longint'($signed(rb));
      run_op(4'd1, ra, rb, 64'(sp), 5, "mult_rand", 1'b0);
      up = longint'({32'd0, ra}) * longint'({32'd0, rb});
      run_op(4'd2, ra, rb, 64'(up), 5, "multu_rand", 1'b0);
    end

    // mthi then mfhi next cycle; mflo / none through the read port
    mt(4'd5, 32'h1234_5678);
    op = 4'd7; #1;
    check("mfhi_rdata", 64'(rdata), 64'h1234_5678);
    op = 4'd8; #1;
    check("mflo_rdata", 64'(rdata), 64'(m_lo));
    op = 4'd0; #1;
    check("none_rdata", 64'(rdata), 64'd0);
    mt(4'd6, 32'hCAFE_0001);
    op = 4'd8; #1;
    check("mtlo_rdata", 64'(rdata), 64'hCAFE_0001);
    op = 4'd0;

    // mtlo and a second mult while busy must be ignored
    run_op(4'd1, 32'd3, 32'd4, 64'd12, 5, "mult_busy_ignore", 1'b1);

    // Reset three cycles into a mult aborts it with no write
    mt(4'd5, 32'h5555_AAAA);
    @(negedge clk);
    en = 1'b1; op = 4'd1; rs_val = 32'd5; rt_val = 32'd7;
    @(posedge clk); #1;
    en = 1'b0; op = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_write", {hi, lo}, 64'd0);
    check("abort_busy_late", 64'(busy), 64'd0);
    m_hi = '0; m_lo = '0;
    $display("[TB] abort mult after 3 cycles -> hi=%h lo=%h busy=%0d", hi, lo, busy);

    mt(4'd5, 32'hAAAA_5555);
    mt(4'd6, 32'h0F0F_0F0F);

`ifdef MDU_DIV_EN
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10, "div_m7_2", 1'b0);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10, "div_ovf", 1'b0);
    run_op(4'd4, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 10, "divu_100_7", 1'b0);
    run_op(4'd4, 32'd7, 32'd0, 64'h0000_0002_0000_000E, 10, "divu_by0", 1'b0);
`else
    // Divide opcodes are plain no-ops in this build
    for (int o = 3; o <= 4; o++) begin
      @(negedge clk);
      en = 1'b1; op = 4'(o); rs_val = 32'd7; rt_val = 32'd2; d_is_md = 1'b1;
      #1;
      check("nodiv_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      en = 1'b0; op = 4'd0;
      check("nodiv_busy", 64'(busy), 64'd0);
      repeat (11) @(posedge clk);
      #1;
      check("nodiv_hilo", {hi, lo}, {m_hi, m_lo});
      d_is_md = 1'b0;
      $display("[TB] nodiv op=%0d -> busy=%0d hi=%h lo=%h", o, busy, hi, lo);
    end
`endif

    // Reserved opcode behaves as none
    @(negedge clk);
    en = 1'b1; op = 4'd9; rs_val = 32'h1111_2222;
    @(posedge clk); #1;
    en = 1'b0; op = 4'd0;
    check("op9_busy", 64'(busy), 64'd0);
    check("op9_hilo", {hi, lo}, {m_hi, m_lo});
    $display("[TB] op=9 -> busy=%0d hi=%h lo=%h", busy, hi, lo);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, SHALL set the number of busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, SHALL set the number of busy cycles for div/divu.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port en, input, 1 bit, SHALL mean the E-stage instruction is valid (not flushed, not stalled).
REQ-006 Port op, input, 4 bits, SHALL be the E-stage MDU opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 are treated as none.
REQ-007 Port rs_val, input, 32 bits, SHALL be the forwarded rs operand.
REQ-008 Port rt_val, input, 32 bits, SHALL be the forwarded rt operand.
REQ-009 Port d_is_md, input, 1 bit, SHALL mean the D-stage instruction is any MDU op (1-8).
REQ-010 Port busy, output, 1 bit, SHALL mean an operation is in progress.
REQ-011 Port stall, output, 1 bit, SHALL be the D-stage stall request.
REQ-012 Ports hi and lo, output, 32 bits each, SHALL be the architectural HI and LO registers.
REQ-013 Port rdata, output, 32 bits, SHALL be the mfhi/mflo read result.

Function
REQ-014 The block SHALL define start = en & (op in 1..4) & ~busy as a combinational signal.
REQ-015 The FSM SHALL have states IDLE, MUL and DIV; busy SHALL be 1 exactly when the state is MUL or DIV.
REQ-016 On start, the block SHALL latch rs_val, rt_val and the op, and enter MUL (op 1/2) or DIV (op 3/4), loading the counter with MULT_CYCLES or DIV_CYCLES.
REQ-017 In MUL or DIV, the counter SHALL decrement each cycle; at the edge where it reaches zero the block SHALL write the results to HI/LO and return to IDLE, so busy is high for exactly N cycles after the start edge.
REQ-018 mult SHALL produce {HI,LO} = signed 64-bit product; multu SHALL produce the unsigned 64-bit product.
REQ-019 div SHALL set LO = signed quotient truncated toward zero and HI = remainder with the sign of the dividend; divu SHALL produce the unsigned quotient and remainder.
REQ-020 For division with a latched divisor of 0, the block SHALL run the full DIV_CYCLES and then leave HI/LO unchanged.
REQ-021 For div, 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0.
REQ-022 When en & ~busy, mthi SHALL load HI <= rs_val and mtlo SHALL load LO <= rs_val at the next edge.
REQ-023 While busy, any op with en SHALL be ignored: no start, no mthi/mtlo write, and operands not relatched.
REQ-024 rdata SHALL be hi when op = 7, lo when op = 8, and 0 otherwise; it is combinational and does not depend on en.
REQ-025 stall SHALL equal d_is_md & (busy | start) combinationally.
REQ-026 Results written at the completing edge SHALL be visible on hi/lo in the cycle busy first reads 0.

Reset
REQ-027 When reset = 1 at a clock edge, the block SHALL set the state to IDLE, the counter to 0, hi and lo to 0, and clear the latched operands, which makes busy and stall (absent start) 0.
REQ-028 Reset SHALL take priority over start and mthi/mtlo, and reset mid-operation SHALL abort with no HI/LO update.

Configuration
REQ-029 With macro MDU_DIV_EN defined, div/divu SHALL behave per REQ-016..REQ-021.
REQ-030 Without MDU_DIV_EN, ops 3 and 4 SHALL be treated as none: no start, no stall contribution, HI/LO unchanged, and the DIV state and divider logic SHALL be omitted.

Verification
REQ-031 mult with rs = 0xFFFFFFFE (-2) and rt = 3 -> busy high for 5 cycles, then HI = 0xFFFFFFFF and LO = 0xFFFFFFFA; multu on the same operands -> HI = 0x00000002, LO = 0xFFFFFFFA.
REQ-032 div with rs = -7 and rt = 2 -> busy high for 10 cycles, then LO = 0xFFFFFFFD and HI = 0xFFFFFFFF; divu 7/0 -> HI/LO keep their prior values.
REQ-033 mthi 0x12345678, then mfhi on the next cycle -> rdata = 0x12345678; a mtlo issued while busy -> LO unchanged.
REQ-034 d_is_md = 1 in the start cycle and through busy -> stall = 1 for 1+N cycles, then 0.
REQ-035 reset asserted 3 cycles into a mult -> busy = 0, HI = LO = 0 on the next cycle, and the result is never written.
REQ-036 Build without MDU_DIV_EN, then issue op = 3 -> busy stays 0 and HI/LO are unchanged.
